// File: rtl/symbol_freq_counter.sv
// symbol_freq_counter
// Front end of the Huffman sort chain. It counts how often each symbol occurs
// in one message. After the message's last symbol it sends a one-cycle preset
// pulse, then streams one (address, count) pair per cycle for every symbol.
// It then pulses done and clears all counters, ready for the next message.
// Every output comes from a flop. Each *_d value is computed from the next
// state, so the outputs line up exactly with the state they describe.

module symbol_freq_counter #(
  parameter int DATA_WIDTH    = 16,
  parameter int TOTAL_SYMBOLS = 10,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sym_valid,
  input  logic [ADDR_WIDTH-1:0] sym_in,
  input  logic                  sym_last,
  output logic                  in_ready,
  output logic                  out_sload,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  done,
  output logic                  sym_err
);

  typedef enum logic [1:0] {
    S_COUNT  = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // The symbol count is widened by one bit, so the range check compares
  // the whole symbol value. No out-of-range symbol can alias onto a counter.
  localparam logic [ADDR_WIDTH:0]   NUM_SYM  = (ADDR_WIDTH+1)'(TOTAL_SYMBOLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_SYMBOLS - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;

  logic                    in_ready_q,  in_ready_d;
  logic                    out_sload_q, out_sload_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
  logic                    done_q,      done_d;
  logic                    sym_err_q,   sym_err_d;

  // Flattened view of all counters, used by the stream read mux
  logic [TOTAL_SYMBOLS-1:0][DATA_WIDTH-1:0] cnt_all;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic accept;
  logic in_range;
  logic count_en;
  logic bad_sym;
  logic clear_cnt;

  // Symbols are accepted only while counting. Anything offered in other states is ignored.
  assign accept    = (state_q == S_COUNT) && sym_valid;
  assign in_range  = ({1'b0, sym_in} < NUM_SYM);
  assign count_en  = accept && in_range;
  assign bad_sym   = accept && !in_range;
  // Counters clear on the edge that leaves DONE
  assign clear_cnt = (state_q == S_DONE);

  // ---------------------------------------------------------------------
  // Per-symbol saturating counters
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_SYMBOLS; gi++) begin : g_cnt
      logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
      logic                  hit;

      assign hit = count_en && (sym_in == ADDR_WIDTH'(gi));

      // Next count: clear after the stream, otherwise increment on a hit, holding at full scale
      always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt) begin
          cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end

      // Counter register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State and stream index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COUNT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: COUNT -> LOAD -> STREAM (TOTAL_SYMBOLS cycles) -> DONE -> COUNT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COUNT:  if (accept && sym_last) state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:   state_d = S_COUNT;
      default:  state_d = S_COUNT;
    endcase
  end

  // Stream index: reset to 0 in LOAD, then step once per STREAM cycle
  always_comb begin
    idx_d = idx_q;
    if (state_q == S_LOAD) begin
      idx_d = '0;
    end else if ((state_q == S_STREAM) && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + ADDR_WIDTH'(1);
    end
  end

  // Read mux: selects the counter the next stream cycle will present
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < TOTAL_SYMBOLS; i++) begin
      if (idx_d == ADDR_WIDTH'(i)) begin
        rd_data = cnt_all[i];
      end
    end
  end

  // Output decode from the next state, registered below so outputs only move on clk edges
  always_comb begin
    in_ready_d  = (state_d == S_COUNT);
    out_sload_d = (state_d == S_LOAD);
    out_valid_d = (state_d == S_STREAM);
    done_d      = (state_d == S_DONE);
    out_addr_d  = '0;
    out_data_d  = '0;
    if (state_d == S_STREAM) begin
      out_addr_d = idx_d;
      out_data_d = rd_data;
    end
    sym_err_d   = sym_err_q | bad_sym;
  end

  // Output registers; only reset clears the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_sload_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      sym_err_q   <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_sload_q <= out_sload_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      sym_err_q   <= sym_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_sload = out_sload_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign done      = done_q;
  assign sym_err   = sym_err_q;

endmodule
